// File: rtl/wave_plotter_pkg.sv
// Shared types and default screen geometry for the waveform pixel plotter.
package wave_plotter_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    typedef logic [9:0] x_t;
    typedef logic [8:0] y_t;

    typedef enum logic {
        IDLE = 1'b0,
        SPAN = 1'b1
    } state_e;

endpackage

// File: rtl/span_stepper.sv
// Walks the current row from a first pixel toward a target row, one step per retired pixel.
module span_stepper
    import wave_plotter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  y_t   first_y_i,
    input  y_t   target_y_i,
    input  logic step_i,
    output y_t   cur_y_o,
    output logic last_o
);

    y_t   cur_y_q;
    y_t   target_y_q;
    logic up_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_y_q    <= '0;
            target_y_q <= '0;
            up_q       <= 1'b0;
        end else if (load_i) begin
            cur_y_q    <= first_y_i;
            target_y_q <= target_y_i;
            up_q       <= (target_y_i > first_y_i);
        end else if (step_i && !last_o) begin
            cur_y_q <= up_q ? cur_y_q + 9'd1 : cur_y_q - 9'd1;
        end
    end

    assign cur_y_o = cur_y_q;
    assign last_o  = (cur_y_q == target_y_q);

endmodule

// File: rtl/wave_pixel_plotter.sv
// Turns a stream of waveform points into framebuffer pixel writes; vertical span
// interpolation between adjacent columns is enabled by defining WAVE_PLOTTER_SPAN_EN.
module wave_pixel_plotter
    import wave_plotter_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pt_valid,
    output logic       pt_ready,
    input  logic [9:0] pt_x,
    input  logic [8:0] pt_y,
    input  logic       pt_pen,
    input  logic       flush,
    output logic       fb_we,
    input  logic       fb_ready,
    output logic [9:0] fb_x,
    output logic [8:0] fb_y,
    output logic       fb_color,
    output logic       busy
);

    localparam y_t Y_MAX = y_t'(SCREEN_H - 1);

    state_e state_q;
    logic   fb_we_q;
    logic   fb_color_q;
    x_t     fb_x_q;
    y_t     y_clamp;
    y_t     first_y_d;
    logic   accept;
    logic   in_range;
    logic   retire;
    logic   last;

    assign y_clamp  = (pt_y > Y_MAX) ? Y_MAX : pt_y;
    assign in_range = ({1'b0, pt_x} < 11'(SCREEN_W));
    assign retire   = fb_we_q && fb_ready;
    assign accept   = pt_valid && pt_ready;

`ifdef WAVE_PLOTTER_SPAN_EN
    logic               prev_valid_q;
    x_t                 prev_x_q;
    y_t                 prev_y_q;
    logic signed [10:0] dx;
    logic               adjacent;

    assign dx       = $signed({1'b0, pt_x}) - $signed({1'b0, prev_x_q});
    // A coincident flush forgets prev before the adjacency test.
    assign adjacent = prev_valid_q && !flush && ((dx == 11'sd1) || (dx == -11'sd1));

    always_comb begin
        first_y_d = y_clamp;
        if (adjacent && (y_clamp > prev_y_q)) begin
            first_y_d = prev_y_q + 9'd1;
        end else if (adjacent && (y_clamp < prev_y_q)) begin
            first_y_d = prev_y_q - 9'd1;
        end
    end

    assign pt_ready = (state_q == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_valid_q <= 1'b0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
        end else if (accept) begin
            prev_valid_q <= in_range;
            prev_x_q     <= pt_x;
            prev_y_q     <= y_clamp;
        end else if (flush) begin
            prev_valid_q <= 1'b0;
        end
    end
`else
    assign first_y_d = y_clamp;
    // Single-pixel build never leaves IDLE, so a pending pixel gates acceptance
    // directly; a new point may load in the same cycle the old one retires.
    assign pt_ready  = !reset && (!fb_we_q || fb_ready);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fb_we_q    <= 1'b0;
            fb_x_q     <= '0;
            fb_color_q <= 1'b0;
        end else if (accept) begin
            fb_we_q <= in_range;
            if (in_range) begin
                fb_x_q     <= pt_x;
                fb_color_q <= pt_pen;
`ifdef WAVE_PLOTTER_SPAN_EN
                state_q    <= SPAN;
`endif
            end
        end else if (retire && last) begin
            fb_we_q <= 1'b0;
            state_q <= IDLE;
        end
    end

    span_stepper u_stepper (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept && in_range),
        .first_y_i  (first_y_d),
        .target_y_i (y_clamp),
        .step_i     (retire),
        .cur_y_o    (fb_y),
        .last_o     (last)
    );

    assign fb_we    = fb_we_q;
    assign fb_x     = fb_x_q;
    assign fb_color = fb_color_q;
    assign busy     = (state_q == SPAN);

endmodule

// File: tb/tb_wave_pixel_plotter.sv
// Self-checking bench for wave_pixel_plotter; expectations follow WAVE_PLOTTER_SPAN_EN.
module tb_wave_pixel_plotter;

`ifdef WAVE_PLOTTER_SPAN_EN
    localparam bit SPAN = 1'b1;
    localparam int PRE  = 2;
`else
    localparam bit SPAN = 1'b0;
    localparam int PRE  = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pt_valid = 1'b0;
    logic       pt_pen = 1'b0;
    logic       flush = 1'b0;
    logic       fb_ready = 1'b1;
    logic [9:0] pt_x = '0;
    logic [8:0] pt_y = '0;
    logic       pt_ready;
    logic       fb_we;
    logic       fb_color;
    logic       busy;
    logic [9:0] fb_x;
    logic [8:0] fb_y;

    wave_pixel_plotter #(
        .SCREEN_W (640),
        .SCREEN_H (480)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_x     (pt_x),
        .pt_y     (pt_y),
        .pt_pen   (pt_pen),
        .flush    (flush),
        .fb_we    (fb_we),
        .fb_ready (fb_ready),
        .fb_x     (fb_x),
        .fb_y     (fb_y),
        .fb_color (fb_color),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Pixels still owed to the framebuffer, oldest first.
    int qx[$];
    int qy[$];
    int qc[$];
    // Pixels actually retired by the DUT.
    int lx[$];
    int ly[$];
    int lc[$];
    int lcyc[$];
    int mprev_valid = 0;
    int mprev_x = 0;
    int mprev_y = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_accept(input int x, input int y, input int pen, input int fl);
        int yc;
        int s;
        bit adj;
        yc  = (y > 479) ? 479 : y;
        adj = SPAN && (mprev_valid != 0) && (fl == 0) &&
              ((x - mprev_x == 1) || (mprev_x - x == 1));
        if (x < 640) begin
            if (adj && (yc != mprev_y)) begin
                s = (yc > mprev_y) ? 1 : -1;
                for (int v = mprev_y + s; v != yc + s; v += s) begin
                    qx.push_back(x);
                    qy.push_back(v);
                    qc.push_back(pen);
                end
            end else begin
                qx.push_back(x);
                qy.push_back(yc);
                qc.push_back(pen);
            end
        end
        mprev_x     = x;
        mprev_y     = yc;
        mprev_valid = (x < 640) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            qx.delete();
            qy.delete();
            qc.delete();
            mprev_valid = 0;
            mprev_x     = 0;
            mprev_y     = 0;
        end
        chk("fb_we", int'(fb_we), int'(qx.size() > 0));
        if (qx.size() > 0) begin
            chk("fb_x", int'(fb_x), qx[0]);
            chk("fb_y", int'(fb_y), qy[0]);
            chk("fb_color", int'(fb_color), qc[0]);
        end
        chk("busy", int'(busy), int'(SPAN && (qx.size() > 0)));
        chk("pt_ready", int'(pt_ready),
            int'(!reset && ((qx.size() == 0) || (!SPAN && fb_ready))));
        if (!reset) begin
            if (fb_we && fb_ready && (qx.size() > 0)) begin
                lx.push_back(int'(fb_x));
                ly.push_back(int'(fb_y));
                lc.push_back(int'(fb_color));
                lcyc.push_back(cyc);
                void'(qx.pop_front());
                void'(qy.pop_front());
                void'(qc.pop_front());
            end
            if (pt_valid && pt_ready) begin
                model_accept(int'(pt_x), int'(pt_y), int'(pt_pen), int'(flush));
            end else if (flush) begin
                mprev_valid = 0;
            end
        end
    end

    task automatic send_point(input int x, input int y, input int pen, input int fl);
        bit ok;
        pt_x     = 10'(x);
        pt_y     = 9'(y);
        pt_pen   = pen[0];
        flush    = fl[0];
        pt_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = pt_ready;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got pt_ready=0 for 100 cycles, want 1 for point (%0d,%0d)", x, y);
        end
        @(posedge clk);
        #1;
        pt_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((qx.size() > 0) || fb_we) && (n < 300));
        if (n >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got fb_we=%0d pending=%0d, want idle within 300 cycles",
                     fb_we, qx.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string name, input int base, input int x,
                             input int y_first, input int y_last, input int c);
        int step;
        int cnt;
        step = (y_last >= y_first) ? 1 : -1;
        cnt  = (y_last - y_first) * step + 1;
        chk({name, "_count"}, lx.size() - base, cnt);
        for (int k = 0; k < cnt && (base + k) < lx.size(); k++) begin
            chk({name, "_x"}, lx[base + k], x);
            chk({name, "_y"}, ly[base + k], y_first + k * step);
            chk({name, "_color"}, lc[base + k], c);
        end
    endtask

    initial begin
        int base;
        int hx;
        int hy;

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_x", int'(fb_x), 0);
        chk("rst_fb_y", int'(fb_y), 0);
        chk("rst_fb_color", int'(fb_color), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pt_ready", int'(pt_ready), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Right-edge column, then a rising span one column left.
        send_point(639, 240, 1, 0);
        wait_idle();
        base = lx.size();
        send_point(638, 245, 1, 0);
        chk("t1_latency", int'(fb_we), 1);
        wait_idle();
        check_run("t1", base, 638, SPAN ? 241 : 245, 245, 1);
        for (int k = 1; (base + k) < lcyc.size(); k++) begin
            chk("t1_b2b", lcyc[base + k] - lcyc[base + k - 1], 1);
        end

        // Falling span, erase colour.
        send_point(100, 300, 1, 1);
        wait_idle();
        base = lx.size();
        send_point(99, 296, 0, 0);
        wait_idle();
        check_run("t2", base, 99, SPAN ? 299 : 296, 296, 0);

        // Row clamp, then a span starting from the clamped row.
        base = lx.size();
        send_point(200, 500, 1, 1);
        wait_idle();
        check_run("t3a", base, 200, 479, 479, 1);
        base = lx.size();
        send_point(201, 475, 1, 0);
        wait_idle();
        check_run("t3b", base, 201, SPAN ? 478 : 475, 475, 1);

        // Framebuffer back-pressure for three cycles.
        send_point(300, 100, 1, 1);
        wait_idle();
        base = lx.size();
        send_point(301, 110, 1, 0);
        repeat (PRE) @(posedge clk);
        #1;
        fb_ready = 1'b0;
        hx = int'(fb_x);
        hy = int'(fb_y);
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_x", int'(fb_x), hx);
            chk("t4_hold_y", int'(fb_y), hy);
            chk("t4_we_held", int'(fb_we), 1);
            chk("t4_ready_low", int'(pt_ready), 0);
        end
        @(posedge clk);
        #1;
        fb_ready = 1'b1;
        wait_idle();
        check_run("t4", base, 301, SPAN ? 101 : 110, 110, 1);

        // Flush with the point draws a single pixel; it then seeds the next span.
        send_point(51, 200, 1, 1);
        wait_idle();
        base = lx.size();
        send_point(50, 10, 1, 1);
        wait_idle();
        check_run("t5a", base, 50, 10, 10, 1);
        base = lx.size();
        send_point(49, 12, 0, 0);
        wait_idle();
        check_run("t5b", base, 49, SPAN ? 11 : 12, 12, 0);

        // Off-screen column draws nothing and forgets prev.
        base = lx.size();
        send_point(640, 50, 1, 0);
        wait_idle();
        chk("t6_none", lx.size() - base, 0);
        base = lx.size();
        send_point(639, 60, 1, 0);
        wait_idle();
        check_run("t6b", base, 639, 60, 60, 1);

        // Same row as prev: one pixel.
        send_point(500, 60, 1, 1);
        wait_idle();
        base = lx.size();
        send_point(501, 60, 1, 0);
        wait_idle();
        check_run("t7", base, 501, 60, 60, 1);

        // Flush during a span finishes the span but forgets prev afterwards.
        send_point(400, 20, 1, 1);
        wait_idle();
        base = lx.size();
        send_point(401, 30, 1, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_idle();
        check_run("t8a", base, 401, SPAN ? 21 : 30, 30, 1);
        base = lx.size();
        send_point(402, 25, 1, 0);
        wait_idle();
        check_run("t8b", base, 402, 25, 25, 1);

        // Reset in the middle of a span.
        send_point(10, 0, 1, 1);
        wait_idle();
        send_point(11, 100, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t9_we_reset", int'(fb_we), 0);
        chk("t9_busy_reset", int'(busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        base = lx.size();
        send_point(10, 5, 1, 0);
        wait_idle();
        send_point(9, 50, 1, 0);
        wait_idle();
        chk("t9_writes", lx.size() - base, SPAN ? 46 : 2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
